prio_arbiter: RTL and testbench
===============================

Name: prio_arbiter

Overview:
Parametrised, registered successor to the team's combinational 4-to-2 priority encoder. Takes an N-bit request vector and selects one winner, either by fixed priority (highest index wins) or by round-robin. The winner is presented as a binary index plus a one-hot grant, and is held until the consumer acknowledges it. It sits between multiple requesters (DMA channels, UART/SPI clients) and a single shared resource.

Parameters:
N, 4, number of request lines (N >= 2)
RR, 0, arbitration mode: 0 = fixed priority (index N-1 highest), 1 = round-robin

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
en  input  1  enables new arbitration decisions
req  input  N  request vector, bit i = requester i
ack  input  1  consumer accepts the current grant
valid  output  1  a grant is held
grant_idx  output  IDX_W = max(1, clog2(N))  binary index of the granted requester
grant_oh  output  N  one-hot grant, equal to 1 << grant_idx when valid, else 0

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: valid=0, grant_idx=0, grant_oh=0, state=IDLE, pointer ptr=N-1.
- Priority search:
  - Fixed mode: the highest set index of req wins; ptr is unused.
  - RR mode: search starts at ptr and proceeds downward, wrapping from 0 to N-1. The first set bit wins.
- IDLE state:
  - If en=1 and req!=0: register the winner. Next cycle valid=1 and the outputs show the winner. Go to GRANT. Latency is 1 cycle from req/en sampled to valid.
  - Otherwise stay in IDLE with valid=0.
- GRANT state (lock):
  - Outputs are held stable regardless of changes on req or en.
  - Withdrawal of the granted request does not drop the grant; only ack or reset releases it.
  - If ack=0: hold.
  - If ack=1 in RR mode: ptr <= grant_idx-1, wrapping from 0 to N-1.
  - If ack=1 and en=1 and req!=0: perform a back-to-back re-arbitration in the same cycle, using the updated priority (RR searches from the new ptr value). Stay in GRANT with the new winner and no idle bubble.
  - If ack=1 otherwise: go to IDLE, with valid=0 next cycle and grant_oh=0.
- ack while valid=0 is ignored.
- Fixed mode with the same request still asserted: that request is re-granted back-to-back. This is intended; starvation is possible in fixed mode.
- RR fairness: with all N requests asserted and ack every cycle, the grant sequence is N-1, N-2, …, 0, N-1, …
- Reset mid-GRANT: the grant is dropped and the outputs return to reset values the next cycle. No ack is required.
- grant_idx and grant_oh must always agree when valid=1.
- N a non-power-of-2 (e.g. 5): indices N..2^IDX_W-1 are never produced. Wrap goes from 0 to N-1, never to 2^IDX_W-1.

Decomposition:
- Package prio_arbiter_pkg contains:
  - state enum {IDLE, GRANT};
  - function idx_w(N) returning max(1, clog2(N)).
- Sub-module prio_sel: combinational N-bit priority selector.
  - Inputs: req, start pointer, mode.
  - Outputs: any, idx.
  - Fixed mode forces start to N-1.
  - Implemented by double-width rotate-and-mask or a loop; no latches.
- prio_arbiter holds the FSM, ptr, and the output registers.

Test Plan:
- Reset behaviour: apply reset for 2 cycles with N=4 and req=4'b1111 → valid=0, grant_oh=0000, grant_idx=0 throughout. The first grant appears 1 cycle after reset deasserts.
- Fixed priority selection: RR=0, en=1, req=4'b0110 → next cycle valid=1, grant_idx=2, grant_oh=0100. Hold ack=0 for 3 cycles and change req to 4'b1000 → outputs unchanged. Assert ack → re-grant idx=3 the next cycle.
- Round-robin rotation: RR=1, req=4'b1111, ack=1 every cycle → grant_idx sequence 3,2,1,0,3 with valid continuously 1.
- Round-robin with sparse requests: RR=1, req=4'b1001 with ack each cycle → sequence 3,0,3,0.
- Release to idle: a grant is held and then req goes to 0 → grant stays until ack. On ack, valid=0 the next cycle. Also check en=0 in IDLE with req=1111 → valid stays 0.
- Reset and non-power-of-2 width: reset asserted mid-GRANT → valid=0 next cycle and ptr back to N-1 (next RR grant is 3 for req=1111). With N=5, RR=1, req=5'b11111 → sequence 4,3,2,1,0,4, and grant_idx never exceeds 4.

Source files
------------

// File: rtl/prio_arbiter_pkg.sv
// Shared types and helpers for the registered priority arbiter.
// The state encoding and index-width function are used by prio_arbiter and prio_sel.
package prio_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Width of a binary requester index; never below one bit.
  function automatic int idx_w(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/prio_sel.sv
// Combinational N-bit priority selector: the first set request found searching
// downward from start (wrapping 0 -> N-1) wins; fixed mode always starts at N-1.
module prio_sel
  import prio_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  input  logic             rr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  int               start_s;
  int               pos_s;
  logic [IDX_W-1:0] pos_idx_s;

  // Walk the N candidate positions in priority order and keep the first hit.
  always_comb begin
    any       = 1'b0;
    idx       = {IDX_W{1'b0}};
    start_s   = rr ? int'(start) : (N - 1);
    pos_s     = 0;
    pos_idx_s = {IDX_W{1'b0}};
    for (int k = 0; k < N; k++) begin
      pos_s = start_s - k;
      if (pos_s < 0) begin
        pos_s = pos_s + N;
      end else begin
        pos_s = pos_s;
      end
      pos_idx_s = pos_s[IDX_W-1:0];
      if (!any && req[pos_idx_s]) begin
        any = 1'b1;
        idx = pos_idx_s;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/prio_arbiter.sv
// Registered fixed-priority / round-robin arbiter: grant is locked until ack,
// with back-to-back re-arbitration on ack when new requests are pending.
module prio_arbiter
  import prio_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int RR = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [N-1:0]          req,
  input  logic                  ack,
  output logic                  valid,
  output logic [idx_w(N)-1:0]   grant_idx,
  output logic [N-1:0]          grant_oh
);

  localparam int               IDX_W    = idx_w(N);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1'b1);
  localparam logic             RR_MODE  = (RR != 0);

  state_t           state_r, state_s;
  logic [IDX_W-1:0] ptr_r, ptr_s;
  logic             valid_r, valid_s;
  logic [IDX_W-1:0] idx_r, idx_s;
  logic [N-1:0]     oh_r, oh_s;
  logic [IDX_W-1:0] ptr_dec_s;
  logic [IDX_W-1:0] sel_start_s;
  logic             sel_any_s;
  logic [IDX_W-1:0] sel_idx_s;

  function automatic logic [N-1:0] to_onehot(input logic [IDX_W-1:0] i);
    return {{(N-1){1'b0}}, 1'b1} << i;
  endfunction

  // On ack the pointer moves just below the current winner, wrapping 0 -> N-1,
  // and a back-to-back decision must already see that updated pointer.
  assign ptr_dec_s   = (idx_r == {IDX_W{1'b0}}) ? IDX_LAST : (idx_r - IDX_ONE);
  assign sel_start_s = (state_r == GRANT) ? ptr_dec_s : ptr_r;

  prio_sel #(.N(N), .IDX_W(IDX_W)) u_sel (
    .req   (req),
    .start (sel_start_s),
    .rr    (RR_MODE),
    .any   (sel_any_s),
    .idx   (sel_idx_s)
  );

  // Next-state logic for the IDLE/GRANT lock and the grant registers.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    valid_s = valid_r;
    idx_s   = idx_r;
    oh_s    = oh_r;
    case (state_r)
      IDLE: begin
        if (en && sel_any_s) begin
          state_s = GRANT;
          valid_s = 1'b1;
          idx_s   = sel_idx_s;
          oh_s    = to_onehot(sel_idx_s);
        end else begin
          valid_s = 1'b0;
          idx_s   = {IDX_W{1'b0}};
          oh_s    = {N{1'b0}};
        end
      end
      GRANT: begin
        if (ack) begin
          if (RR_MODE) begin
            ptr_s = ptr_dec_s;
          end else begin
            ptr_s = ptr_r;
          end
          if (en && sel_any_s) begin
            valid_s = 1'b1;
            idx_s   = sel_idx_s;
            oh_s    = to_onehot(sel_idx_s);
          end else begin
            state_s = IDLE;
            valid_s = 1'b0;
            idx_s   = {IDX_W{1'b0}};
            oh_s    = {N{1'b0}};
          end
        end else begin
          state_s = GRANT;
        end
      end
      default: begin
        state_s = IDLE;
        valid_s = 1'b0;
        idx_s   = {IDX_W{1'b0}};
        oh_s    = {N{1'b0}};
      end
    endcase
  end

  // State, pointer and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      ptr_r   <= IDX_LAST;
      valid_r <= 1'b0;
      idx_r   <= {IDX_W{1'b0}};
      oh_r    <= {N{1'b0}};
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      valid_r <= valid_s;
      idx_r   <= idx_s;
      oh_r    <= oh_s;
    end
  end

  assign valid     = valid_r;
  assign grant_idx = idx_r;
  assign grant_oh  = oh_r;

endmodule

// File: tb/tb_prio_arbiter.sv
// Bench for prio_arbiter: three instances (N=4 fixed, N=4 RR, N=5 RR) share
// stimulus; directed scenarios plus random traffic against a behavioural model.
module tb_prio_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, en, ack;
  logic [4:0] req;

  logic       v0, v1, v2;
  logic [1:0] i0, i1;
  logic [2:0] i2;
  logic [3:0] o0, o1;
  logic [4:0] o2;

  prio_arbiter #(.N(4), .RR(0)) u_fix (.clk(clk), .reset(reset), .en(en), .req(req[3:0]),
    .ack(ack), .valid(v0), .grant_idx(i0), .grant_oh(o0));
  prio_arbiter #(.N(4), .RR(1)) u_rr (.clk(clk), .reset(reset), .en(en), .req(req[3:0]),
    .ack(ack), .valid(v1), .grant_idx(i1), .grant_oh(o1));
  prio_arbiter #(.N(5), .RR(1)) u_rr5 (.clk(clk), .reset(reset), .en(en), .req(req),
    .ack(ack), .valid(v2), .grant_idx(i2), .grant_oh(o2));

  int checks = 0;
  int errors = 0;

  // Reference model state, one slot per instance.
  int mn[3]  = '{4, 4, 5};
  int mrr[3] = '{0, 1, 1};
  int mvalid[3];
  int midx[3];
  int mptr[3];

  logic       ov[3];
  int         oi[3];
  logic [4:0] oo[3];
  always_comb begin
    ov[0] = v0; oi[0] = int'(i0); oo[0] = {1'b0, o0};
    ov[1] = v1; oi[1] = int'(i1); oo[1] = {1'b0, o1};
    ov[2] = v2; oi[2] = int'(i2); oo[2] = o2;
  end

  // Winner = first requester met walking down from start, modulo n.
  function automatic int find(int n, logic [4:0] r, int start);
    for (int k = 0; k < n; k++) begin
      int i;
      i = (start - k + n) % n;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_step();
    for (int d = 0; d < 3; d++) begin
      int w;
      if (reset) begin
        mvalid[d] = 0; midx[d] = 0; mptr[d] = mn[d] - 1;
      end else if (mvalid[d] == 0) begin
        w = find(mn[d], req, mrr[d] != 0 ? mptr[d] : mn[d] - 1);
        if (en && w >= 0) begin
          mvalid[d] = 1; midx[d] = w;
        end
      end else if (ack) begin
        if (mrr[d] != 0) mptr[d] = (midx[d] + mn[d] - 1) % mn[d];
        w = find(mn[d], req, mrr[d] != 0 ? mptr[d] : mn[d] - 1);
        if (en && w >= 0) begin
          midx[d] = w;
        end else begin
          mvalid[d] = 0; midx[d] = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; ack = 1'b0; req = 5'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; ack = 1'b0; req = 5'b11111;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (v0 !== 1'b0 || o0 !== 4'b0000 || i0 !== 2'd0 || v1 !== 1'b0 || o1 !== 4'b0000 ||
          i1 !== 2'd0 || v2 !== 1'b0 || o2 !== 5'b00000 || i2 !== 3'd0) begin
        errors++;
        $display("FAIL reset_state cyc%0d: got v=%b%b%b oh=%b/%b/%b idx=%0d/%0d/%0d, want all 0",
                 c, v0, v1, v2, o0, o1, o2, i0, i1, i2);
      end
    end
    reset = 1'b0;
    tick();
    checks++;
    if (v0 !== 1'b1 || i0 !== 2'd3 || o0 !== 4'b1000 || v1 !== 1'b1 || i1 !== 2'd3 ||
        v2 !== 1'b1 || i2 !== 3'd4 || o2 !== 5'b10000) begin
      errors++;
      $display("FAIL first_grant: got v=%b%b%b idx=%0d/%0d/%0d, want v=111 idx=3/3/4",
               v0, v1, v2, i0, i1, i2);
    end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    en = 1'b1; req = 5'b00110;
    tick();
    checks++;
    if (v0 !== 1'b1 || i0 !== 2'd2 || o0 !== 4'b0100) begin
      errors++;
      $display("FAIL fixed_grant: got v=%b idx=%0d oh=%b, want 1 2 0100", v0, i0, o0);
    end
    req = 5'b01000;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (v0 !== 1'b1 || i0 !== 2'd2 || o0 !== 4'b0100) begin
        errors++;
        $display("FAIL fixed_hold cyc%0d: got v=%b idx=%0d oh=%b, want 1 2 0100", c, v0, i0, o0);
      end
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if (v0 !== 1'b1 || i0 !== 2'd3 || o0 !== 4'b1000) begin
      errors++;
      $display("FAIL fixed_regrant: got v=%b idx=%0d oh=%b, want 1 3 1000", v0, i0, o0);
    end
  endtask

  task automatic test_rr_rotation();
    int exp_seq[5] = '{3, 2, 1, 0, 3};
    do_reset();
    en = 1'b1; req = 5'b01111; ack = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (v1 !== 1'b1 || int'(i1) != exp_seq[c] || o1 !== (4'b0001 << exp_seq[c])) begin
        errors++;
        $display("FAIL rr_rotation step%0d: got v=%b idx=%0d oh=%b, want idx=%0d", c, v1, i1, o1, exp_seq[c]);
      end
    end
  endtask

  task automatic test_rr_sparse();
    int exp_seq[4] = '{3, 0, 3, 0};
    do_reset();
    en = 1'b1; req = 5'b01001; ack = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (v1 !== 1'b1 || int'(i1) != exp_seq[c] || o1 !== (4'b0001 << exp_seq[c])) begin
        errors++;
        $display("FAIL rr_sparse step%0d: got v=%b idx=%0d oh=%b, want idx=%0d", c, v1, i1, o1, exp_seq[c]);
      end
    end
  endtask

  task automatic test_release();
    do_reset();
    en = 1'b1; req = 5'b00010; ack = 1'b0;
    tick();
    req = 5'b00000;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (v0 !== 1'b1 || i0 !== 2'd1 || o0 !== 4'b0010) begin
        errors++;
        $display("FAIL release_hold cyc%0d: got v=%b idx=%0d oh=%b, want 1 1 0010", c, v0, i0, o0);
      end
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if (v0 !== 1'b0 || o0 !== 4'b0000 || v1 !== 1'b0 || o1 !== 4'b0000) begin
      errors++;
      $display("FAIL release_idle: got v=%b%b oh=%b/%b, want v=00 oh=0", v0, v1, o0, o1);
    end
    en = 1'b0; req = 5'b01111;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (v0 !== 1'b0 || v1 !== 1'b0 || o0 !== 4'b0000) begin
        errors++;
        $display("FAIL en_low_idle cyc%0d: got v=%b%b oh=%b, want v=00 oh=0000", c, v0, v1, o0);
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    en = 1'b1; req = 5'b01111; ack = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (v1 !== 1'b0 || o1 !== 4'b0000 || v0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_grant: got v=%b%b oh=%b, want v=00 oh=0000", v0, v1, o1);
    end
    reset = 1'b0; ack = 1'b0;
    tick();
    checks++;
    if (v1 !== 1'b1 || i1 !== 2'd3) begin
      errors++;
      $display("FAIL ptr_after_reset: got v=%b idx=%0d, want 1 3", v1, i1);
    end
  endtask

  task automatic test_non_pow2();
    int exp_seq[6] = '{4, 3, 2, 1, 0, 4};
    do_reset();
    en = 1'b1; req = 5'b11111; ack = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (v2 !== 1'b1 || int'(i2) != exp_seq[c] || i2 > 3'd4 || o2 !== (5'b00001 << exp_seq[c])) begin
        errors++;
        $display("FAIL n5_rotation step%0d: got v=%b idx=%0d oh=%b, want idx=%0d", c, v2, i2, o2, exp_seq[c]);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 39) == 0);
      en    = ($urandom_range(0, 3) != 0);
      ack   = $urandom_range(0, 1) == 1;
      req   = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) req = 5'b0;
      tick();
      for (int d = 0; d < 3; d++) begin
        logic [4:0] exp_oh;
        exp_oh = (mvalid[d] != 0) ? (5'b00001 << midx[d]) : 5'b00000;
        checks++;
        if (ov[d] !== (mvalid[d] != 0) || oo[d] !== exp_oh ||
            (mvalid[d] != 0 && oi[d] != midx[d])) begin
          errors++;
          $display("FAIL random dut%0d cyc%0d: got v=%b idx=%0d oh=%b, want v=%0d idx=%0d oh=%b",
                   d, c, ov[d], oi[d], oo[d], mvalid[d], midx[d], exp_oh);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; ack = 1'b0; req = 5'b0;
    for (int d = 0; d < 3; d++) begin
      mvalid[d] = 0; midx[d] = 0; mptr[d] = mn[d] - 1;
    end
    test_reset();
    test_fixed_priority();
    test_rr_rotation();
    test_rr_sparse();
    test_release();
    test_reset_mid_grant();
    test_non_pow2();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
